// File: rtl/byte_stream_pkg.sv
// Shared byte-stream types and helpers.
// Used by the deserializer and its serializer peer.
package byte_stream_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    FILL,
    HOLD
  } deser_state_t;

  // Lane that the cnt-th byte of a word occupies.
  function automatic int unsigned lane_of(
    input int unsigned cnt,
    input int unsigned size,
    input bit          msb_first
  );
    return msb_first ? size - 1 - cnt : cnt;
  endfunction

endpackage

// File: rtl/byte_deser_if.sv
// Byte-in / word-out handshake bundle.
// slave = deserializer, master = its surroundings.
interface byte_deser_if #(
  parameter int SIZE = 7
) ();

  logic [7:0]                   byte_in;
  logic                         byte_valid;
  logic                         byte_ready;
  logic                         flush;
  logic [8*SIZE-1:0]            word_out;
  logic [$clog2(SIZE+1)-1:0]    word_count;
  logic                         word_valid;
  logic                         word_ready;

  modport master (
    output byte_in, byte_valid, flush, word_ready,
    input  byte_ready, word_out, word_count, word_valid
  );

  modport slave (
    input  byte_in, byte_valid, flush, word_ready,
    output byte_ready, word_out, word_count, word_valid
  );

endinterface

// File: rtl/byte_lane_counter.sv
// Byte counter for the word being filled.
// Gives the lane to write plus last/empty flags.
module byte_lane_counter
  import byte_stream_pkg::*;
#(
  parameter int SIZE      = 7,
  parameter bit MSB_FIRST = 1'b0,
  parameter int CW        = $clog2(SIZE+1),
  parameter int LW        = $clog2(SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic          load1,
  output logic [CW-1:0] cnt,
  output logic [LW-1:0] lane,
  output logic          last,
  output logic          empty
);

  // Saturating count; only clear or load1 bring it back down.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= CW'(1);
    end else if (inc && cnt != CW'(SIZE)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Lane index and flags decoded from the count.
  always_comb begin
    lane  = LW'(lane_of(int'(cnt), SIZE, MSB_FIRST));
    last  = (cnt == CW'(SIZE-1));
    empty = (cnt == '0);
  end

endmodule

// File: rtl/byte_deser.sv
// Byte-stream deserializer: gathers SIZE bytes
// into one word, handed off on valid/ready.
module byte_deser
  import byte_stream_pkg::*;
#(
  parameter int SIZE      = 7,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic          clk,
  input logic          rst,
  byte_deser_if.slave  bus
);

  localparam int CW = $clog2(SIZE+1);
  localparam int LW = $clog2(SIZE);
  localparam logic [LW-1:0] FIRST_LANE =
    LW'(lane_of(0, SIZE, MSB_FIRST));

  deser_state_t      state;
  logic [CW-1:0]     cnt;
  logic [LW-1:0]     lane;
  logic              last;
  logic              empty;
  logic [CW-1:0]     count_q;
  logic              valid_q;
  logic [BYTE_W-1:0] lane_q [SIZE];
  logic [8*SIZE-1:0] word;
  logic              acc;
  logic              take;
  logic [LW-1:0]     wr_lane;

  // Handshake decode; in HOLD a take frees the slot for a byte.
  always_comb begin
    bus.byte_ready = !rst && (state == FILL || bus.word_ready);
    acc     = bus.byte_valid && bus.byte_ready;
    take    = (state == HOLD) && bus.word_ready;
    wr_lane = (state == FILL) ? lane : FIRST_LANE;
  end

  byte_lane_counter #(
    .SIZE      (SIZE),
    .MSB_FIRST (MSB_FIRST)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (take && !acc),
    .inc   ((state == FILL) && acc),
    .load1 (take && acc),
    .cnt   (cnt),
    .lane  (lane),
    .last  (last),
    .empty (empty)
  );

  // Word register: per-lane write enable, cleared on take.
  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    always_ff @(posedge clk) begin
      if (rst) begin
        lane_q[i] <= '0;
      end else if (acc && wr_lane == LW'(i)) begin
        lane_q[i] <= bus.byte_in;
      end else if (take) begin
        lane_q[i] <= '0;
      end
    end
  end

  // Flatten lanes onto the output word.
  always_comb begin
    word = '0;
    for (int i = 0; i < SIZE; i++) begin
      word[i*BYTE_W +: BYTE_W] = lane_q[i];
    end
  end

  // FILL/HOLD control with registered word_valid/word_count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FILL;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state)
        FILL: begin
          if (acc && (last || bus.flush)) begin
            state   <= HOLD;
            valid_q <= 1'b1;
            count_q <= last ? CW'(SIZE) : cnt + CW'(1);
          end else if (bus.flush && !empty) begin
            state   <= HOLD;
            valid_q <= 1'b1;
            count_q <= cnt;
          end
        end
        HOLD: begin
          if (bus.word_ready) begin
            state   <= FILL;
            valid_q <= 1'b0;
            count_q <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign bus.word_out   = word;
  assign bus.word_count = count_q;
  assign bus.word_valid = valid_q;

endmodule

// File: tb/tb_byte_deser.sv
// Bench for byte_deser: LSB-first and MSB-first
// instances against a queue-based word model.
module tb_byte_deser;

  logic       clk;
  logic       rst;
  logic       byte_valid;
  logic [7:0] byte_in;
  logic       flush;
  logic       word_ready;

  byte_deser_if #(.SIZE(7)) ifa ();
  byte_deser_if #(.SIZE(7)) ifb ();

  assign ifa.byte_in    = byte_in;
  assign ifa.byte_valid = byte_valid;
  assign ifa.flush      = flush;
  assign ifa.word_ready = word_ready;
  assign ifb.byte_in    = byte_in;
  assign ifb.byte_valid = byte_valid;
  assign ifb.flush      = flush;
  assign ifb.word_ready = word_ready;

  byte_deser #(.SIZE(7), .MSB_FIRST(1'b0)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  byte_deser #(.SIZE(7), .MSB_FIRST(1'b1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: bytes of the current word in arrival order.
  logic [7:0]  mq[$];
  bit          m_hold  = 1'b0;
  bit          m_acc   = 1'b0;
  bit          started = 1'b0;
  bit          rt      = 1'b0;
  logic [55:0] exp_a[$];
  logic [55:0] exp_b[$];

  function automatic logic [55:0] build(input bit msb);
    logic [55:0] w;
    int          l;
    w = '0;
    for (int k = 0; k < mq.size(); k++) begin
      l = msb ? 6 - k : k;
      w[l*8 +: 8] = mq[k];
    end
    return w;
  endfunction

  function automatic logic [55:0] byterev(input logic [55:0] w);
    logic [55:0] v;
    for (int k = 0; k < 7; k++) v[(6-k)*8 +: 8] = w[k*8 +: 8];
    return v;
  endfunction

  task automatic model_step();
    m_acc   = 1'b0;
    started = 1'b1;
    if (rst) begin
      mq.delete();
      m_hold = 1'b0;
    end else if (!m_hold) begin
      if (byte_valid) begin
        m_acc = 1'b1;
        mq.push_back(byte_in);
        if (mq.size() == 7 || flush) m_hold = 1'b1;
      end else if (flush && mq.size() > 0) begin
        m_hold = 1'b1;
      end
    end else if (word_ready) begin
      m_hold = 1'b0;
      mq.delete();
      if (byte_valid) begin
        m_acc = 1'b1;
        mq.push_back(byte_in);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: DUT outputs vs model every cycle.
  initial forever begin
    @(negedge clk);
    if (started) begin
      check("byte_ready_a", ifa.byte_ready,
            !rst && (!m_hold || word_ready));
      check("byte_ready_b", ifb.byte_ready,
            !rst && (!m_hold || word_ready));
      check("valid_a", ifa.word_valid, m_hold);
      check("valid_b", ifb.word_valid, m_hold);
      if (m_hold) begin
        check("count_a", ifa.word_count, mq.size());
        check("count_b", ifb.word_count, mq.size());
        check("word_a", ifa.word_out, build(1'b0));
        check("word_b", ifb.word_out, build(1'b1));
      end
      if (rt && ifa.word_valid && word_ready) begin
        if (exp_a.size() == 0) begin
          check("rt_extra_word", 1, 0);
        end else begin
          check("rt_a", ifa.word_out, exp_a.pop_front());
          check("rt_b", ifb.word_out, exp_b.pop_front());
        end
      end
    end
  end

  task automatic cyc(input bit bv, input logic [7:0] b,
                     input bit fl, input bit wr);
    byte_valid = bv;
    byte_in    = b;
    flush      = fl;
    word_ready = wr;
    @(posedge clk);
    #1;
  endtask

  logic [55:0] w;
  logic [7:0]  sq[$];
  int          guard;

  initial begin
    rst = 1'b1;
    cyc(0, 8'h00, 0, 0);
    cyc(1, 8'h5A, 1, 1);
    check("rst_ready", ifa.byte_ready, 0);
    check("rst_valid", ifa.word_valid, 0);
    check("rst_count", ifa.word_count, 0);
    check("rst_word", ifa.word_out, 0);
    rst = 1'b0;

    // Back-to-back 11..77, consumer always ready.
    for (int k = 1; k <= 7; k++) begin
      cyc(1, 8'(k * 17), 0, 1);
      if (k == 6) check("early_valid", ifa.word_valid, 0);
    end
    check("lsb_word", ifa.word_out, 56'h77665544332211);
    check("msb_word", ifb.word_out, 56'h11223344556677);
    check("full_count", ifa.word_count, 7);
    check("full_valid", ifa.word_valid, 1);
    cyc(0, 8'h00, 0, 1);
    check("taken_valid", ifa.word_valid, 0);

    // Backpressure for 5 cycles, then take with AA.
    for (int k = 1; k <= 7; k++) cyc(1, 8'(k), 0, 0);
    for (int k = 0; k < 5; k++) begin
      byte_valid = 1'b1;
      byte_in    = 8'h55;
      word_ready = 1'b0;
      #1;
      check("bp_ready", ifa.byte_ready, 0);
      @(posedge clk);
      #1;
      check("bp_hold", ifa.word_out, 56'h07060504030201);
    end
    cyc(1, 8'hAA, 0, 1);
    check("aa_valid", ifa.word_valid, 0);
    check("aa_lane_a", ifa.word_out, 56'hAA);
    check("aa_lane_b", ifb.word_out, 56'hAA000000000000);
    cyc(0, 8'h00, 1, 0);
    check("aa_count", ifa.word_count, 1);
    cyc(0, 8'h00, 0, 1);

    // Flush of a partial word, then flush with nothing held.
    cyc(1, 8'h33, 0, 1);
    cyc(1, 8'h44, 0, 1);
    cyc(0, 8'h00, 1, 1);
    check("flush_word", ifa.word_out, 56'h4433);
    check("flush_count", ifa.word_count, 2);
    cyc(0, 8'h00, 1, 1);
    cyc(0, 8'h00, 1, 1);
    check("empty_flush", ifa.word_valid, 0);

    // Flush together with the last byte.
    cyc(1, 8'h01, 0, 1);
    cyc(1, 8'h02, 0, 1);
    cyc(1, 8'h03, 1, 1);
    check("sim_word", ifa.word_out, 56'h030201);
    check("sim_count", ifa.word_count, 3);
    cyc(0, 8'h00, 0, 1);

    // Reset mid-fill, then a clean word.
    for (int k = 1; k <= 4; k++) cyc(1, 8'(8'hF0 + k), 0, 0);
    rst = 1'b1;
    cyc(1, 8'hEE, 0, 0);
    rst = 1'b0;
    check("mid_rst_word", ifa.word_out, 0);
    check("mid_rst_valid", ifa.word_valid, 0);
    check("mid_rst_count", ifa.word_count, 0);
    for (int k = 1; k <= 7; k++) cyc(1, 8'(8'h20 + k), 0, 0);
    check("clean_word", ifa.word_out, 56'h27262524232221);
    cyc(0, 8'h00, 0, 1);

    // Round trip: words serialized lane 0 first.
    for (int n = 0; n < 100; n++) begin
      w = {$urandom, $urandom};
      exp_a.push_back(w);
      exp_b.push_back(byterev(w));
      for (int k = 0; k < 7; k++) sq.push_back(w[k*8 +: 8]);
    end
    rt    = 1'b1;
    guard = 0;
    while ((sq.size() > 0 || exp_a.size() > 0) && guard < 10000) begin
      if (sq.size() > 0)
        cyc($urandom_range(3) != 0, sq[0], 0, $urandom_range(3) != 0);
      else
        cyc(0, 8'h00, 0, $urandom_range(3) != 0);
      if (m_acc) void'(sq.pop_front());
      guard++;
    end
    cyc(0, 8'h00, 0, 0);
    rt = 1'b0;
    check("rt_timeout", guard < 10000, 1);
    check("rt_left", exp_a.size(), 0);

    // Random traffic with flush and occasional reset.
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(63) == 0);
      cyc($urandom_range(2) != 0, 8'($urandom),
          $urandom_range(7) == 0, $urandom_range(1) == 1);
    end
    rst = 1'b0;
    cyc(0, 8'h00, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
